// File: rtl/lcd_bus_engine.sv
// lcd_bus_engine
//   Queues command/data entries for an 8080-style parallel LCD bus and plays
//   them out as SETUP / LOW / HIGH strobe sequences, back-to-back when the
//   queue stays non-empty.
//
//   Ports
//     clk, reset_n               clock, synchronous active-low reset
//     in_valid/in_ready          entry handshake; in_dcx, in_rd, in_data payload
//     cfg_low, cfg_high          strobe low / high widths (0 behaves as 1)
//     ctrl_res_n, ctrl_lcd_on    requested panel reset / enable levels
//     rd_valid, rd_data          read-back pulse and last captured value
//     busy, fifo_level           activity flag and queue occupancy
//     lcd_*                      registered panel pins; lcd_d_in sampled on reads
//
//   The pins are registered from the FSM state, so they trail the state by
//   one cycle. An entry pushed into an empty, idle engine is popped on the
//   next edge and appears on the pins on the edge after that.
module lcd_bus_engine #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_dcx,
  input  logic                          in_rd,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [CNT_W-1:0]              cfg_low,
  input  logic [CNT_W-1:0]              cfg_high,
  input  logic                          ctrl_res_n,
  input  logic                          ctrl_lcd_on,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          lcd_res_n,
  output logic                          lcd_csx,
  output logic                          lcd_wrx,
  output logic                          lcd_rdx,
  output logic                          lcd_dcx,
  output logic                          lcd_on,
  output logic [DATA_W-1:0]             lcd_d_out,
  output logic                          lcd_d_oe,
  input  logic [DATA_W-1:0]             lcd_d_in
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_LOW   = 2'd2,
    ST_HIGH  = 2'd3
  } state_t;

  // A programmed width of zero still gives one strobe cycle.
  function automatic logic [CNT_W-1:0] f_min1(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b0}}) ? CNT_W'(1) : v;
  endfunction

  // Queue storage and pointers
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_count;

  // Transaction state
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_len_low;
  logic [CNT_W-1:0]  r_len_high;
  logic              r_e_dcx;
  logic              r_e_rd;
  logic [DATA_W-1:0] r_e_data;
  logic              r_last_low_rd;

  // Registered outputs
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_lcd_res_n;
  logic              r_lcd_csx;
  logic              r_lcd_wrx;
  logic              r_lcd_rdx;
  logic              r_lcd_dcx;
  logic              r_lcd_on;
  logic [DATA_W-1:0] r_lcd_d_out;
  logic              r_lcd_d_oe;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_head;
  logic              w_last_high;

  assign w_full      = (r_count == LW'(FIFO_DEPTH));
  assign w_empty     = (r_count == {LW{1'b0}});
  assign w_push      = in_valid & ~w_full;
  assign w_last_high = (r_state == ST_HIGH) && (r_cnt == CNT_W'(1));
  // A new transaction starts only from IDLE or the final HIGH cycle, and
  // never while the panel is held in reset.
  assign w_pop       = ~w_empty & r_lcd_res_n &
                       ((r_state == ST_IDLE) | w_last_high);
  assign w_head      = r_mem[r_rd_ptr];

  assign in_ready    = ~w_full;
  assign fifo_level  = r_count;
  assign busy        = ~w_empty | (r_state != ST_IDLE) | ~r_lcd_csx;

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign lcd_res_n   = r_lcd_res_n;
  assign lcd_csx     = r_lcd_csx;
  assign lcd_wrx     = r_lcd_wrx;
  assign lcd_rdx     = r_lcd_rdx;
  assign lcd_dcx     = r_lcd_dcx;
  assign lcd_on      = r_lcd_on;
  assign lcd_d_out   = r_lcd_d_out;
  assign lcd_d_oe    = r_lcd_d_oe;

  // Queue storage write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_dcx, in_rd, in_data};
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {LW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Transaction FSM, pin drivers and read capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_len_low     <= CNT_W'(1);
      r_len_high    <= CNT_W'(1);
      r_e_dcx       <= 1'b0;
      r_e_rd        <= 1'b0;
      r_e_data      <= {DATA_W{1'b0}};
      r_last_low_rd <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= {DATA_W{1'b0}};
      r_lcd_res_n   <= 1'b0;
      r_lcd_on      <= 1'b0;
      r_lcd_csx     <= 1'b1;
      r_lcd_wrx     <= 1'b1;
      r_lcd_rdx     <= 1'b1;
      r_lcd_dcx     <= 1'b1;
      r_lcd_d_out   <= {DATA_W{1'b0}};
      r_lcd_d_oe    <= 1'b0;
    end else begin
      // Latch the popped entry and the timing that applies to it.
      if (w_pop) begin
        r_e_dcx    <= w_head[DATA_W+1];
        r_e_rd     <= w_head[DATA_W];
        r_e_data   <= w_head[DATA_W-1:0];
        r_len_low  <= f_min1(cfg_low);
        r_len_high <= f_min1(cfg_high);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_state <= ST_LOW;
          r_cnt   <= r_len_low;
        end
        ST_LOW: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_HIGH;
            r_cnt   <= r_len_high;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= w_pop ? ST_SETUP : ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Pins reflect the state of the previous cycle.
      case (r_state)
        ST_IDLE: begin
          r_lcd_csx  <= 1'b1;
          r_lcd_wrx  <= 1'b1;
          r_lcd_rdx  <= 1'b1;
          r_lcd_d_oe <= 1'b0;
        end
        ST_SETUP: begin
          r_lcd_csx  <= 1'b0;
          r_lcd_wrx  <= 1'b1;
          r_lcd_rdx  <= 1'b1;
          r_lcd_dcx  <= r_e_dcx;
          r_lcd_d_oe <= ~r_e_rd;
          if (r_e_rd) begin
            r_lcd_d_out <= r_lcd_d_out;
          end else begin
            r_lcd_d_out <= r_e_data;
          end
        end
        ST_LOW: begin
          r_lcd_csx  <= 1'b0;
          r_lcd_wrx  <= r_e_rd;
          r_lcd_rdx  <= ~r_e_rd;
          r_lcd_d_oe <= ~r_e_rd;
        end
        ST_HIGH: begin
          r_lcd_csx <= 1'b0;
          r_lcd_wrx <= 1'b1;
          r_lcd_rdx <= 1'b1;
        end
        default: begin
          r_lcd_csx  <= 1'b1;
          r_lcd_wrx  <= 1'b1;
          r_lcd_rdx  <= 1'b1;
          r_lcd_d_oe <= 1'b0;
        end
      endcase

      // Flag that the pins are in the final LOW cycle of a read; the edge
      // ending that cycle captures the panel data.
      r_last_low_rd <= (r_state == ST_LOW) && (r_cnt == CNT_W'(1)) && r_e_rd;
      r_rd_valid    <= r_last_low_rd;
      if (r_last_low_rd) begin
        r_rd_data <= lcd_d_in;
      end else begin
        r_rd_data <= r_rd_data;
      end

      r_lcd_res_n <= ctrl_res_n;
      r_lcd_on    <= ctrl_lcd_on;
    end
  end

endmodule

// File: doc/lcd_bus_engine.md
LCD_BUS_ENGINE -- requirements
Module: lcd_bus_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16: LCD data bus width; legal values 8 and 16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: command FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter CNT_W, default 8: width of the timing configuration fields.
REQ-004 SHALL have ports as follows; one clock; reset is synchronous and active-low:
  clk  in  1  sole clock; all state updates on its rising edge
  reset_n  in  1  synchronous active-low reset
  in_valid  in  1  upstream entry valid
  in_ready  out  1  FIFO can accept an entry
  in_dcx  in  1  entry type: 0 = command, 1 = data
  in_rd  in  1  entry is a bus read (1) or write (0)
  in_data  in  DATA_W  write payload; ignored for reads
  cfg_low  in  CNT_W  strobe-low width in cycles
  cfg_high  in  CNT_W  strobe-high width in cycles
  ctrl_res_n  in  1  requested panel reset level
  ctrl_lcd_on  in  1  requested backlight/enable level
  rd_valid  out  1  one-cycle pulse: rd_data valid
  rd_data  out  DATA_W  last captured read value
  busy  out  1  FIFO non-empty or FSM not IDLE
  fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
  lcd_res_n, lcd_csx, lcd_wrx, lcd_rdx, lcd_dcx, lcd_on  out  1 each  panel pins
  lcd_d_out  out  DATA_W  panel data driven
  lcd_d_oe  out  1  drive enable for lcd_d_out
  lcd_d_in  in  DATA_W  panel data sampled on reads

Function
REQ-005 SHALL implement a FIFO of FIFO_DEPTH entries {dcx, rd, data}; push on in_valid & in_ready; in_ready = not full.
REQ-006 SHALL NOT accept a push when full, even if a pop occurs in the same cycle; simultaneous push and pop when not full SHALL leave fifo_level unchanged.
REQ-007 SHALL pop only when non-empty and the FSM is in IDLE or at the last HIGH cycle.
REQ-008 SHALL implement FSM states IDLE, SETUP, LOW, HIGH.
REQ-009 IDLE -> SETUP when FIFO non-empty and lcd_res_n = 1; the popped entry is latched; cfg_low/cfg_high are latched at this pop; a value of 0 SHALL be treated as 1.
REQ-010 SETUP, 1 cycle: lcd_csx = 0, lcd_dcx = entry dcx; for writes, lcd_d_out = entry data and lcd_d_oe = 1; for reads, lcd_d_oe = 0; strobes high.
REQ-011 LOW, L = latched cfg_low cycles: lcd_wrx = 0 (write) or lcd_rdx = 0 (read), the other strobe = 1.
REQ-012 On a read, SHALL capture lcd_d_in into rd_data at the edge ending the last LOW cycle, and SHALL assert rd_valid for exactly the following cycle.
REQ-013 HIGH, H = latched cfg_high cycles: both strobes = 1; data, dcx and oe held.
REQ-014 At the end of HIGH, if the FIFO is non-empty and lcd_res_n = 1, the FSM SHALL pop and go to SETUP with lcd_csx held 0 (back-to-back); otherwise it SHALL go to IDLE with lcd_csx = 1 and lcd_d_oe = 0.
REQ-015 Each transaction SHALL occupy exactly 1 + L + H cycles.
REQ-016 All lcd_* outputs SHALL be registered; lcd_csx SHALL fall on the 2nd rising edge after the accepting edge of an entry pushed into an empty FIFO while IDLE.
REQ-017 lcd_res_n and lcd_on SHALL follow ctrl_res_n and ctrl_lcd_on with a 1-cycle register delay.
REQ-018 While lcd_res_n = 0, no new transaction SHALL start; a transaction in progress SHALL complete.
REQ-019 lcd_wrx and lcd_rdx SHALL never be low simultaneously; lcd_d_oe SHALL be 0 whenever lcd_rdx = 0.
REQ-020 busy and fifo_level SHALL be combinational from registered state.

Reset
REQ-021 When reset_n = 0 at a rising edge, the block SHALL set: FIFO empty, state IDLE, lcd_csx = lcd_wrx = lcd_rdx = lcd_dcx = 1, lcd_d_out = 0, lcd_d_oe = 0, lcd_res_n = 0, lcd_on = 0, rd_valid = 0, rd_data = 0.
REQ-022 A reset asserted mid-transaction SHALL abort it; all strobes SHALL be high after that edge, and no rd_valid SHALL be issued for the aborted read.

Verification
REQ-023 Single write: cfg_low = 2, cfg_high = 3, push {dcx=0, rd=0, data=0x002C} -> csx low 6 cycles, wrx low 2 cycles, d_out = 0x002C, oe = 1, dcx = 0.
REQ-024 Read: cfg_low = 4, cfg_high = 1, push {dcx=1, rd=1}, lcd_d_in = 0xA5A5 -> rdx low 4 cycles, oe = 0, rd_valid pulse with rd_data = 0xA5A5.
REQ-025 Back-to-back: push 3 writes, cfg 1/1 -> csx low continuously for 9 cycles, 3 wrx pulses, data 0x0001/0x0002/0x0003 in order.
REQ-026 Full and zero-config: FIFO_DEPTH = 4, ctrl_res_n = 0, push 5 entries -> in_ready = 0 after 4, fifo_level = 4; cfg_low = 0 -> wrx low exactly 1 cycle once ctrl_res_n = 1.
REQ-027 Reset mid-LOW of a read -> strobes and csx = 1 next cycle, no rd_valid, fifo_level = 0.
